// File: rtl/fmap_wb_pkg.sv
// Shared definitions for the feature-map writeback stage: FSM encoding and
// the default element geometry agreed with the pooling stage.
package fmap_wb_pkg;

   localparam int unsigned DEF_DW = 8;
   localparam int unsigned DEF_DN = 7;
   localparam int unsigned DEF_AW = 10;
   localparam int unsigned DEF_FD = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous first-word-fall-through FIFO; pop_data always shows the head
// entry while empty is low.
module wb_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW:0]  wr_ptr_q, wr_ptr_d;
   logic [PW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         push_en;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      push_en  = push && !full;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      pop_data = mem_q[rd_ptr_q[PW-1:0]];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q[PW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/fmap_wb.sv
// Feature-map writeback: buffers pooled words from upstream and writes a
// configured run of them into one of two RAM banks, one word per granted cycle.
module fmap_wb
   import fmap_wb_pkg::*;
#(
   parameter int unsigned DW = DEF_DW,
   parameter int unsigned DN = DEF_DN,
   parameter int unsigned AW = DEF_AW,
   parameter int unsigned FD = DEF_FD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DN*DW-1:0] m_data,
   input  logic             m_valid,
   output logic             m_ready,
   input  logic             cfg_start,
   input  logic             cfg_bank,
   input  logic [AW-1:0]    cfg_base,
   input  logic [AW-1:0]    cfg_len,
   input  logic             ram_gnt,
   output logic [1:0]       ram_we,
   output logic [AW-1:0]    ram_addr,
   output logic [DN*DW-1:0] ram_wdata,
   output logic             busy,
   output logic             done
);

   localparam int unsigned WW = DN * DW;

   wb_state_e     state_q, state_d;
   logic          bank_q, bank_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] len_q, len_d;
   logic [AW-1:0] acc_cnt_q, acc_cnt_d;
   logic [AW-1:0] wr_cnt_q, wr_cnt_d;

   logic          fifo_full, fifo_empty;
   logic          push, pop;
   logic [WW-1:0] fifo_head;

   wb_fifo #(
      .W    (WW),
      .DEPTH(FD)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(m_data),
      .pop      (pop),
      .pop_data (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      bank_d    = bank_q;
      base_d    = base_q;
      len_d     = len_q;
      acc_cnt_d = acc_cnt_q;
      wr_cnt_d  = wr_cnt_q;

      m_ready   = (state_q == ST_RUN) && !fifo_full && (acc_cnt_q != len_q);
      push      = m_valid && m_ready;
      // A write in the same cycle as reset would land after the abort, so block it.
      pop       = (state_q == ST_RUN) && !fifo_empty && ram_gnt && !rst;
      ram_we    = pop ? {bank_q, ~bank_q} : 2'b00;
      ram_addr  = base_q + wr_cnt_q;
      ram_wdata = pop ? fifo_head : '0;
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_DONE);

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               bank_d    = cfg_bank;
               base_d    = cfg_base;
               len_d     = cfg_len;
               acc_cnt_d = '0;
               wr_cnt_d  = '0;
               state_d   = (cfg_len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (push) begin
               acc_cnt_d = acc_cnt_q + 1'b1;
            end
            if (pop) begin
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (wr_cnt_d == len_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bank_q    <= 1'b0;
         base_q    <= '0;
         len_q     <= '0;
         acc_cnt_q <= '0;
         wr_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         bank_q    <= bank_d;
         base_q    <= base_d;
         len_q     <= len_d;
         acc_cnt_q <= acc_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
      end
   end

endmodule

// File: tb/tb_fmap_wb.sv
// Directed scoreboard bench for fmap_wb: expected RAM writes are queued when a
// layer is started and consumed as the DUT strobes ram_we.
module tb_fmap_wb;

   localparam int AW = 10;
   localparam int WW = 8 * 7;

   typedef struct packed {
      logic [1:0]    we;
      logic [AW-1:0] addr;
      logic [WW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [WW-1:0] m_data = '0;
   logic          m_valid = 1'b0;
   logic          m_ready;
   logic          cfg_start = 1'b0;
   logic          cfg_bank = 1'b0;
   logic [AW-1:0] cfg_base = '0;
   logic [AW-1:0] cfg_len = '0;
   logic          ram_gnt = 1'b0;
   logic [1:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [WW-1:0] ram_wdata;
   logic          busy;
   logic          done;

   wr_t           exp_q[$];
   logic [WW-1:0] src_q[$];
   bit            src_en = 1'b0;
   bit            src_fire = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int layer_wr = 0;
   int done_cnt = 0;
   int first_wr_cyc = -1;
   int last_wr_cyc = -1;
   int done_cyc = -1;
   int acc_total = 0;
   int start_cyc = 0;
   int acc0 = 0;

   fmap_wb #(
      .DW(8),
      .DN(7),
      .AW(AW),
      .FD(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .cfg_start(cfg_start),
      .cfg_bank (cfg_bank),
      .cfg_base (cfg_base),
      .cfg_len  (cfg_len),
      .ram_gnt  (ram_gnt),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Upstream source: presents the queue head, advances on a sampled handshake.
   always @(negedge clk) src_fire = m_valid && m_ready && !rst;

   always @(posedge clk) begin
      #2;
      if (src_fire && src_q.size() > 0) begin
         void'(src_q.pop_front());
         acc_total++;
      end
      src_fire = 1'b0;
      m_valid  = src_en && (src_q.size() > 0);
      m_data   = (src_q.size() > 0) ? src_q[0] : '0;
   end

   // Write monitor / scoreboard consumer.
   always @(negedge clk) begin
      wr_t e;
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (ram_we !== 2'b00) begin
         if (layer_wr == 0) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
         layer_wr++;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 128'({ram_we, ram_addr, ram_wdata}), 128'(0));
         end else begin
            e = exp_q.pop_front();
            chk("ram_write", 128'({ram_we, ram_addr, ram_wdata}), 128'(e));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic start_layer(input logic bank, input logic [AW-1:0] base,
                              input logic [AW-1:0] len, input int n_words, input int n_exp);
      logic [WW-1:0] w;
      wr_t e;
      for (int i = 0; i < n_words; i++) begin
         w = WW'({$urandom(), $urandom()});
         src_q.push_back(w);
         if (i < n_exp) begin
            e.we   = bank ? 2'b10 : 2'b01;
            e.addr = AW'(base + AW'(i));
            e.data = w;
            exp_q.push_back(e);
         end
      end
      src_en = 1'b1;
      tick();
      tick();
      layer_wr     = 0;
      done_cnt     = 0;
      first_wr_cyc = -1;
      last_wr_cyc  = -1;
      done_cyc     = -1;
      acc0         = acc_total;
      cfg_bank     = bank;
      cfg_base     = base;
      cfg_len      = len;
      cfg_start    = 1'b1;
      start_cyc    = cyc;
      tick();
      cfg_start    = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      do begin
         sample();
         n++;
      end while (done !== 1'b1 && n < max);
      chk("done_seen", 128'(done), 128'(1));
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      tick();
      sample();
      chk("rst_m_ready", 128'(m_ready), 128'(0));
      chk("rst_ram_we", 128'(ram_we), 128'(0));
      chk("rst_ram_addr", 128'(ram_addr), 128'(0));
      chk("rst_ram_wdata", 128'(ram_wdata), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      tick();
      rst = 1'b0;
      tick();

      // Streaming into bank 1
      ram_gnt = 1'b1;
      start_layer(1'b1, 10'h010, 10'd4, 4, 4);
      wait_done(50);
      chk("stream_first_latency", 128'(first_wr_cyc), 128'(start_cyc + 2));
      chk("stream_back_to_back", 128'(last_wr_cyc - first_wr_cyc), 128'(3));
      chk("stream_done_timing", 128'(done_cyc), 128'(last_wr_cyc + 1));
      tick();
      sample();
      chk("stream_done_one_cycle", 128'(done), 128'(0));
      chk("stream_idle_busy", 128'(busy), 128'(0));
      chk("stream_writes", 128'(layer_wr), 128'(4));
      chk("stream_sb_empty", 128'(exp_q.size()), 128'(0));
      chk("stream_done_cnt", 128'(done_cnt), 128'(1));

      // Stall with grant withheld
      ram_gnt = 1'b0;
      start_layer(1'b0, 10'h020, 10'd6, 6, 6);
      repeat (10) tick();
      sample();
      chk("stall_accepts", 128'(acc_total - acc0), 128'(4));
      chk("stall_m_ready", 128'(m_ready), 128'(0));
      chk("stall_no_writes", 128'(layer_wr), 128'(0));
      chk("stall_busy", 128'(busy), 128'(1));
      tick();
      ram_gnt = 1'b1;
      wait_done(60);
      tick();
      sample();
      chk("stall_writes", 128'(layer_wr), 128'(6));
      chk("stall_sb_empty", 128'(exp_q.size()), 128'(0));
      chk("stall_accept_total", 128'(acc_total - acc0), 128'(6));

      // Address wrap
      start_layer(1'b0, 10'h3FE, 10'd4, 4, 4);
      wait_done(50);
      tick();
      sample();
      chk("wrap_writes", 128'(layer_wr), 128'(4));
      chk("wrap_sb_empty", 128'(exp_q.size()), 128'(0));

      // Zero length
      start_layer(1'b1, 10'h055, 10'd0, 0, 0);
      sample();
      chk("zero_done", 128'(done), 128'(1));
      chk("zero_m_ready", 128'(m_ready), 128'(0));
      tick();
      sample();
      chk("zero_done_drop", 128'(done), 128'(0));
      chk("zero_busy", 128'(busy), 128'(0));
      chk("zero_writes", 128'(layer_wr), 128'(0));

      // Overrun plus repeated start while running
      start_layer(1'b1, 10'h040, 10'd2, 3, 2);
      cfg_start = 1'b1;
      cfg_bank  = 1'b0;
      cfg_base  = 10'h200;
      cfg_len   = 10'd7;
      tick();
      tick();
      cfg_start = 1'b0;
      wait_done(50);
      repeat (5) tick();
      sample();
      chk("overrun_writes", 128'(layer_wr), 128'(2));
      chk("overrun_sb_empty", 128'(exp_q.size()), 128'(0));
      chk("overrun_third_left", 128'(src_q.size()), 128'(1));
      chk("overrun_m_ready", 128'(m_ready), 128'(0));
      chk("overrun_done_cnt", 128'(done_cnt), 128'(1));
      tick();
      src_en = 1'b0;
      src_q.delete();
      cfg_bank = 1'b0;
      cfg_base = '0;
      cfg_len  = '0;

      // Reset in the middle of a layer
      ram_gnt = 1'b0;
      start_layer(1'b0, 10'h080, 10'd5, 5, 2);
      repeat (6) tick();
      ram_gnt = 1'b1;
      tick();
      tick();
      rst    = 1'b1;
      src_en = 1'b0;
      src_q.delete();
      tick();
      sample();
      chk("midrst_m_ready", 128'(m_ready), 128'(0));
      chk("midrst_ram_we", 128'(ram_we), 128'(0));
      chk("midrst_ram_addr", 128'(ram_addr), 128'(0));
      chk("midrst_ram_wdata", 128'(ram_wdata), 128'(0));
      chk("midrst_busy", 128'(busy), 128'(0));
      tick();
      rst = 1'b0;
      repeat (5) tick();
      sample();
      chk("midrst_writes", 128'(layer_wr), 128'(2));
      chk("midrst_no_done", 128'(done_cnt), 128'(0));
      chk("midrst_sb_empty", 128'(exp_q.size()), 128'(0));

      // Fresh layer after the abort
      start_layer(1'b1, 10'h100, 10'd3, 3, 3);
      wait_done(50);
      tick();
      sample();
      chk("fresh_first_latency", 128'(first_wr_cyc), 128'(start_cyc + 2));
      chk("fresh_writes", 128'(layer_wr), 128'(3));
      chk("fresh_sb_empty", 128'(exp_q.size()), 128'(0));
      chk("fresh_done_cnt", 128'(done_cnt), 128'(1));

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fmap_wb.md
FMAP_WB -- requirements
Module: fmap_wb

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning bits per pooled element.
REQ-002 The block SHALL have parameter DN, default 7, meaning elements per stream word.
REQ-003 The block SHALL have parameter AW, default 10, meaning feature-RAM address width.
REQ-004 The block SHALL have parameter FD, default 4, meaning input FIFO depth (power of two, at least 2).
REQ-005 clk  in  1  sole clock; all logic is on the rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 m_data  in  DN*DW  pooled word from the upstream max-pool stage.
REQ-008 m_valid  in  1  m_data is valid.
REQ-009 m_ready  out  1  the block accepts m_data this cycle.
REQ-010 cfg_start  in  1  single-cycle start of a layer writeback.
REQ-011 cfg_bank  in  1  target RAM bank (0/1), latched at start.
REQ-012 cfg_base  in  AW  first write address, latched at start.
REQ-013 cfg_len  in  AW  number of words to write, latched at start.
REQ-014 ram_gnt  in  1  RAM port granted this cycle (CPU-side arbitration).
REQ-015 ram_we  out  2  one-hot write strobe, bit n selects bank n.
REQ-016 ram_addr  out  AW  write address.
REQ-017 ram_wdata  out  DN*DW  write data.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse when the layer is fully written.

Function
REQ-020 The FSM SHALL have states IDLE, RUN and DONE.
REQ-021 IDLE->RUN SHALL occur on cfg_start with latched cfg_len non-zero; IDLE->DONE on cfg_start with cfg_len==0.
REQ-022 cfg_start SHALL be ignored outside IDLE.
REQ-023 m_ready SHALL equal (state==RUN) && !fifo_full && (acc_cnt != len_q).
REQ-024 A word SHALL be accepted iff m_valid && m_ready, pushing m_data into the FIFO and incrementing acc_cnt.
REQ-025 A RAM write SHALL issue iff state==RUN && fifo non-empty && ram_gnt: ram_we[bank_q]=1, ram_addr=base_q+wr_cnt (mod 2^AW), ram_wdata=FIFO head, then pop and increment wr_cnt.
REQ-026 Latency from acceptance into an empty FIFO to ram_we with ram_gnt held high SHALL be exactly 1 cycle; throughput SHALL be one word per cycle.
REQ-027 Simultaneous push and pop on a full FIFO SHALL NOT be allowed (m_ready is low when full); simultaneous push and pop at any other occupancy SHALL leave occupancy unchanged.
REQ-028 RUN->DONE SHALL occur in the cycle after the write that makes wr_cnt==len_q.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-030 Words presented with m_valid after acc_cnt==len_q SHALL stay unaccepted (m_ready=0) and SHALL NOT be written.
REQ-031 ram_gnt low SHALL stall writes without data loss; upstream SHALL be back-pressured once the FIFO is full.
REQ-032 acc_cnt and wr_cnt SHALL be AW bits wide; cfg_len up to 2^AW-1 is supported.

Reset
REQ-033 On rst: state=IDLE, FIFO empty, acc_cnt=wr_cnt=0, bank_q/base_q/len_q=0; m_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0.
REQ-034 rst mid-layer SHALL abort the layer immediately, with no further RAM writes and no done pulse.

Structure
REQ-035 The shared package SHALL hold the FSM state encoding and the default DW/DN/AW values shared with the pooling stage.
REQ-036 The FIFO SHALL be a separate sub-module, wb_fifo: synchronous, first-word-fall-through, with full/empty flags.

Verification
REQ-037 Streaming: base=0x010, len=4, bank=1, ram_gnt=1, words A,B,C,D back-to-back -> ram_we=2'b10 at addresses 0x010..0x013 with data A..D on consecutive cycles; done 1 cycle after the last write.
REQ-038 Stall: len=6, ram_gnt=0 for 10 cycles -> m_ready drops after 4 accepts; after ram_gnt=1, all 6 words are written in order, with none lost or duplicated.
REQ-039 Wrap: base=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-040 Zero length: cfg_start with len=0 -> done on the next cycle, no ram_we, m_ready stays 0.
REQ-041 Overrun/ignored start: len=2, upstream sends 3 words, cfg_start repeated during RUN -> exactly 2 writes, third word not accepted, latched config unchanged.
REQ-042 Reset mid-run: rst asserted after 2 of 5 writes -> outputs at reset values next cycle, no done; a new start afterwards behaves as a fresh layer.
